alu_bist: RTL and testbench

- Synthesizable self-test engine for the 4-bit MiniALU. It sits at the other end of the ALU's 11-in/6-out interface.
- Drives all 2048 input vectors in ascending order, samples the ALU's 6 outputs and compares them with an internal golden model.
- Reports pass/fail, the error count and the first failing vector.
- Lets the board check the ALU in hardware, with no simulator testbench.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_bist_if.sv | 10 +
 rtl/alu_golden.sv | 46 ++++
 rtl/alu_bist.sv | 94 +++++++++
 tb/tb_alu_bist.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants, field positions and FSM state type for the MiniALU self-test
package alu_pkg;

  localparam int VEC_W   = 11;
  localparam int OUT_W   = 6;
  localparam int NUM_VEC = 2048;
  localparam int ERR_W   = 12;

  localparam logic [VEC_W-1:0] LAST_VEC = 11'h7FF;

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;
  localparam logic [1:0] SEL_AND = 2'b10;
  localparam logic [1:0] SEL_XOR = 2'b11;

  // Operand bits are interleaved on alu_in: A(i) at IN_A0+2i, B(i) at IN_B0+2i.
  localparam int IN_CIN    = 0;
  localparam int IN_A0     = 1;
  localparam int IN_B0     = 2;
  localparam int IN_STRIDE = 2;
  localparam int IN_SA     = 9;
  localparam int IN_SB     = 10;

  localparam int OUT_C0   = 0;
  localparam int OUT_COUT = 4;
  localparam int OUT_SC   = 5;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    WAIT,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/alu_bist_if.sv
// rtl/alu_bist_if.sv - vector/response bus between the self-test engine and the ALU under test
interface alu_bist_if;

  logic [alu_pkg::VEC_W-1:0] alu_in;
  logic [alu_pkg::OUT_W-1:0] alu_out;

  modport master (output alu_in, input alu_out);
  modport slave  (input alu_in, output alu_out);

endinterface

// File: rtl/alu_golden.sv
// rtl/alu_golden.sv - combinational reference MiniALU: 11-bit vector in, expected 6-bit response out
module alu_golden
  import alu_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic [OUT_W-1:0] expected
);

  logic [1:0] sel;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [4:0] sum;
  logic       sc;

  always_comb begin
    a   = '0;
    b   = '0;
    sum = '0;
    sc  = 1'b0;
    sel = {vec[IN_SB], vec[IN_SA]};
    cin = vec[IN_CIN];
    for (int i = 0; i < 4; i++) begin
      a[i] = vec[IN_A0 + IN_STRIDE*i];
      b[i] = vec[IN_B0 + IN_STRIDE*i];
    end
    case (sel)
      SEL_ADD: begin
        sum = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        sc  = (a[3] == b[3]) && (sum[3] != a[3]);
      end
      SEL_SUB: begin
        sum = {1'b0, a} + {1'b0, ~b} + {4'b0, cin};
        sc  = (a[3] != b[3]) && (sum[3] != a[3]);
      end
      SEL_AND: sum = {1'b0, a & b};
      SEL_XOR: sum = {1'b0, a ^ b};
      default: sum = '0;
    endcase
    expected                  = '0;
    expected[OUT_SC]          = sc;
    expected[OUT_COUT]        = sum[4];
    expected[OUT_C0 +: 4]     = sum[3:0];
  end

endmodule

// File: rtl/alu_bist.sv
// rtl/alu_bist.sv - sweeps all 2048 ALU vectors, compares against the golden model, reports results
module alu_bist
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter bit STOP_ON_FAIL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  alu_bist_if.master       bus,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [VEC_W-1:0] first_fail_vec
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [VEC_W-1:0] vec;
  logic [3:0]       settle_cnt;
  logic [OUT_W-1:0] expected;
  logic             mismatch;

  alu_golden u_golden (
    .vec      (vec),
    .expected (expected)
  );

  assign mismatch = (bus.alu_out != expected);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      vec              <= '0;
      settle_cnt       <= '0;
      bus.alu_in       <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= APPLY;
            vec              <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
          end
        end
        APPLY: begin
          bus.alu_in <= vec;
          settle_cnt <= SETTLE_LOAD;
          state      <= WAIT;
        end
        WAIT: begin
          if (settle_cnt == 4'd0) state <= CHECK;
          else settle_cnt <= settle_cnt - 4'd1;
        end
        CHECK: begin
          if (mismatch) begin
            err_count <= err_count + 12'd1;
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec   <= vec;
            end
          end
          // Last-vector test comes before the increment so vec never wraps mid-sweep.
          if ((mismatch && STOP_ON_FAIL) || (vec == LAST_VEC)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch;
          end else begin
            vec   <= vec + 11'd1;
            state <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// tb/tb_alu_bist.sv - directed checks of alu_bist against behavioural ALUs with planted faults
module tb_alu_bist;

  logic        clk = 1'b0;
  logic [2:0]  rst;
  logic [2:0]  start;
  logic [2:0]  busy, done, pass, ffv;
  logic [11:0] err   [3];
  logic [10:0] ffvec [3];
  logic [10:0] alu_in_s [3];
  int          mode  [3];
  logic [10:0] fvec  [3];

  logic [10:0] gvec;
  logic [5:0]  gexp;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Independent ALU model: signed-range overflow and unsigned carry, plus fault injection.
  function automatic logic [5:0] alu_model(logic [10:0] v, int m, logic [10:0] fv);
    int a, b, cin, sa, sb, r, s;
    logic [3:0] c;
    logic co, sc;
    logic [5:0] o;
    a   = {28'd0, v[7], v[5], v[3], v[1]};
    b   = {28'd0, v[8], v[6], v[4], v[2]};
    cin = {31'd0, v[0]};
    sa  = (a > 7) ? a - 16 : a;
    sb  = (b > 7) ? b - 16 : b;
    co  = 1'b0;
    sc  = 1'b0;
    case ({v[10], v[9]})
      2'b00: begin
        r = a + b + cin; s = sa + sb + cin;
        c = r[3:0]; co = (r > 15); sc = (s > 7) || (s < -8);
      end
      2'b01: begin
        r = a + (15 - b) + cin; s = sa - sb - 1 + cin;
        c = r[3:0]; co = (r > 15); sc = (s > 7) || (s < -8);
      end
      2'b10: c = 4'(a & b);
      default: c = 4'(a ^ b);
    endcase
    o = {sc, co, c};
    if (m == 1) o[4] = ~o[4];
    if (m == 2 && v == fv) o[0] = ~o[0];
    return o;
  endfunction

  alu_bist_if bus0 ();
  alu_bist_if bus1 ();
  alu_bist_if bus2 ();

  assign bus0.alu_out = alu_model(bus0.alu_in, mode[0], fvec[0]);
  assign bus1.alu_out = alu_model(bus1.alu_in, mode[1], fvec[1]);
  assign bus2.alu_out = alu_model(bus2.alu_in, mode[2], fvec[2]);
  assign alu_in_s[0]  = bus0.alu_in;
  assign alu_in_s[1]  = bus1.alu_in;
  assign alu_in_s[2]  = bus2.alu_in;

  alu_bist u0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .bus(bus0),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err[0]),
    .first_fail_valid(ffv[0]), .first_fail_vec(ffvec[0])
  );

  alu_bist #(.STOP_ON_FAIL(1'b1)) u1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .bus(bus1),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err[1]),
    .first_fail_valid(ffv[1]), .first_fail_vec(ffvec[1])
  );

  alu_bist #(.SETTLE_CYCLES(3)) u2 (
    .clk(clk), .rst(rst[2]), .start(start[2]), .bus(bus2),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(err[2]),
    .first_fail_valid(ffv[2]), .first_fail_vec(ffvec[2])
  );

  alu_golden u_gold (.vec(gvec), .expected(gexp));

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(int i, string tag);
    check_eq({tag, "_alu_in"}, alu_in_s[i], 0);
    check_eq({tag, "_busy"},   busy[i], 0);
    check_eq({tag, "_done"},   done[i], 0);
    check_eq({tag, "_pass"},   pass[i], 0);
    check_eq({tag, "_err"},    err[i], 0);
    check_eq({tag, "_ffv"},    ffv[i], 0);
    check_eq({tag, "_ffvec"},  ffvec[i], 0);
  endtask

  task automatic kick(int i, string tag);
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
    check_eq({tag, "_busy_next"}, busy[i], 1);
    check_eq({tag, "_done_clr"},  done[i], 0);
    check_eq({tag, "_err_clr"},   err[i], 0);
  endtask

  // Counts edges after the start edge until done; optionally pokes start while busy.
  task automatic run_sweep(int i, int hold, bit poke, output int cycles, output int bad_runs);
    int last_chg;
    logic [10:0] prev;
    last_chg = -1;
    prev     = alu_in_s[i];
    cycles   = 0;
    bad_runs = 0;
    while (!done[i] && cycles < 20000) begin
      start[i] = poke && (cycles == 10 || cycles == 777 || cycles == 3001);
      @(posedge clk); #1;
      cycles++;
      if (alu_in_s[i] != prev) begin
        if (last_chg >= 0 && cycles - last_chg != hold) bad_runs++;
        last_chg = cycles;
        prev     = alu_in_s[i];
      end
    end
    start[i] = 1'b0;
    check_eq("sweep_reached_done", done[i], 1);
  endtask

  initial begin
    int cyc, bad, cnt;
    rst   = 3'b111;
    start = 3'b000;
    for (int i = 0; i < 3; i++) begin
      mode[i] = 0;
      fvec[i] = '0;
    end

    gvec = 11'h02E; #1 check_eq("gold_add_ovf",   gexp, 6'h28);
    gvec = 11'h0AF; #1 check_eq("gold_add_carry", gexp, 6'h11);
    gvec = 11'h205; #1 check_eq("gold_sub_neg",   gexp, 6'h0F);
    gvec = 11'h285; #1 check_eq("gold_sub_ovf",   gexp, 6'h37);
    gvec = 11'h4EF; #1 check_eq("gold_and",       gexp, 6'h05);
    gvec = 11'h7B0; #1 check_eq("gold_xor",       gexp, 6'h06);

    repeat (3) @(posedge clk);
    #1;
    check_reset(0, "rst0");
    check_reset(1, "rst1");
    check_reset(2, "rst2");
    rst = 3'b000;
    @(posedge clk); #1;

    kick(0, "good");
    run_sweep(0, 3, 1'b0, cyc, bad);
    check_eq("good_cycles", cyc, 6144);
    check_eq("good_pass",   pass[0], 1);
    check_eq("good_err",    err[0], 0);
    check_eq("good_ffv",    ffv[0], 0);
    check_eq("good_busy",   busy[0], 0);

    mode[0] = 1;
    kick(0, "cout");
    run_sweep(0, 3, 1'b0, cyc, bad);
    check_eq("cout_err",   err[0], 2048);
    check_eq("cout_ffvec", ffvec[0], 0);
    check_eq("cout_ffv",   ffv[0], 1);
    check_eq("cout_pass",  pass[0], 0);

    mode[0] = 2;
    fvec[0] = 11'h5A3;
    kick(0, "one");
    run_sweep(0, 3, 1'b0, cyc, bad);
    check_eq("one_err",   err[0], 1);
    check_eq("one_ffvec", ffvec[0], 11'h5A3);
    check_eq("one_ffv",   ffv[0], 1);
    check_eq("one_pass",  pass[0], 0);

    mode[0] = 0;
    kick(0, "mid");
    cnt = 0;
    while (alu_in_s[0] != 11'd100 && cnt < 2000) begin
      @(posedge clk); #1;
      cnt++;
    end
    check_eq("mid_reach_100", alu_in_s[0], 100);
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    check_eq("mid_poke_busy", busy[0], 1);
    check_eq("mid_poke_vec",  alu_in_s[0], 100);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    check_reset(0, "midrst");
    rst[0] = 1'b0;
    @(posedge clk); #1;
    kick(0, "after");
    run_sweep(0, 3, 1'b1, cyc, bad);
    check_eq("after_cycles", cyc, 6144);
    check_eq("after_pass",   pass[0], 1);
    check_eq("after_err",    err[0], 0);

    mode[1] = 2;
    fvec[1] = 11'h010;
    kick(1, "stop");
    run_sweep(1, 3, 1'b0, cyc, bad);
    check_eq("stop_cycles", cyc, 51);
    check_eq("stop_err",    err[1], 1);
    check_eq("stop_alu_in", alu_in_s[1], 11'h010);
    check_eq("stop_ffvec",  ffvec[1], 11'h010);
    check_eq("stop_pass",   pass[1], 0);

    kick(2, "s3");
    run_sweep(2, 5, 1'b0, cyc, bad);
    check_eq("s3_cycles",    cyc, 10240);
    check_eq("s3_hold_runs", bad, 0);
    check_eq("s3_pass",      pass[2], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
